// File: rtl/loop_pkg.sv
// Shared constants, state encoding and helpers for the loop mixer.
package loop_pkg;

  localparam int NUM_LOOPS = 4;
  localparam int SAMPLE_W  = 32;
  localparam int ACC_W     = 35;
  localparam int GAIN_W    = 3;
  localparam int IDX_W     = 3;   // counts the live term plus NUM_LOOPS loop terms

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Largest positive and most negative SAMPLE_W values, expressed at accumulator width
  localparam logic signed [ACC_W-1:0] MAX_POS =
    $signed({{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] MAX_NEG =
    $signed({{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}});

  // Sign-extend one audio sample to accumulator width
  function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] x);
    return $signed({{(ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x});
  endfunction

endpackage

// File: rtl/loop_sat.sv
// Combinational saturator: clamps a wide signed accumulator to one audio sample.
module loop_sat
  import loop_pkg::*;
(
  input  logic signed [ACC_W-1:0]    i_acc,
  output logic        [SAMPLE_W-1:0] o_sample,
  output logic                       o_clip
);

  // Clamp to the representable sample range and flag when clamping occurred
  always_comb begin
    o_sample = i_acc[SAMPLE_W-1:0];
    o_clip   = 1'b0;
    if (i_acc > MAX_POS) begin
      o_sample = MAX_POS[SAMPLE_W-1:0];
      o_clip   = 1'b1;
    end else if (i_acc < MAX_NEG) begin
      o_sample = MAX_NEG[SAMPLE_W-1:0];
      o_clip   = 1'b1;
    end
  end

endmodule

// File: rtl/loop_mixer.sv
// Sums the live codec input and the per-loop playback samples, saturates the
// result and hands it to the codec output port.
// Codec handshake: write_audio_out is asserted only while a mixed sample is
// pending and audio_out_allowed is high; the sample transfers on that edge and
// the pending sample is then retired.
module loop_mixer
  import loop_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [SAMPLE_W-1:0]           left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]           right_channel_audio_in,
  input  logic [NUM_LOOPS*SAMPLE_W-1:0] loop_left_in,
  input  logic [NUM_LOOPS*SAMPLE_W-1:0] loop_right_in,
  input  logic [NUM_LOOPS-1:0]          channel_enable,
  input  logic                          monitor_en,
  input  logic [NUM_LOOPS*GAIN_W-1:0]   gain_shift,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [SAMPLE_W-1:0]           left_channel_audio_out,
  output logic [SAMPLE_W-1:0]           right_channel_audio_out,
  output logic                          clip_left,
  output logic                          clip_right,
  output logic                          overrun,
  output logic                          busy
);

  state_t                        r_state;
  state_t                        w_next;
  logic [IDX_W-1:0]              r_idx;
  logic [SAMPLE_W-1:0]           r_live_l, r_live_r;
  logic [NUM_LOOPS*SAMPLE_W-1:0] r_loop_l, r_loop_r;
  logic [NUM_LOOPS-1:0]          r_en;
  logic                          r_mon;
  logic [NUM_LOOPS*GAIN_W-1:0]   r_gain;
  logic signed [ACC_W-1:0]       r_acc_l, r_acc_r;
  logic [SAMPLE_W-1:0]           r_out_l, r_out_r;
  logic                          r_clip_l, r_clip_r;
  logic                          r_overrun;

  logic [IDX_W-1:0]              w_loop_sel;
  logic [SAMPLE_W-1:0]           w_sel_l, w_sel_r;
  logic [GAIN_W-1:0]             w_sh;
  logic                          w_use;
  logic signed [SAMPLE_W-1:0]    w_shl_l, w_shl_r;
  logic signed [ACC_W-1:0]       w_term_l, w_term_r;
  logic [SAMPLE_W-1:0]           w_sat_l, w_sat_r;
  logic                          w_clip_l, w_clip_r;

  // idx 1..NUM_LOOPS addresses loop idx-1; idx 0 is the live term
  assign w_loop_sel = r_idx - IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; ticks are only accepted from IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next = ACCUM;
      ACCUM:   if (r_idx == IDX_W'(NUM_LOOPS)) w_next = SAT;
      SAT:     w_next = OUT;
      OUT:     if (audio_out_allowed) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Select and scale the term added this ACCUM cycle, both channels in parallel
  always_comb begin
    w_sel_l  = '0;
    w_sel_r  = '0;
    w_sh     = '0;
    w_use    = 1'b0;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      if (int'(w_loop_sel) == k) begin
        w_sel_l = r_loop_l[k*SAMPLE_W +: SAMPLE_W];
        w_sel_r = r_loop_r[k*SAMPLE_W +: SAMPLE_W];
        w_sh    = r_gain[k*GAIN_W +: GAIN_W];
        w_use   = r_en[k];
      end
    end
    w_shl_l  = $signed(w_sel_l) >>> w_sh;
    w_shl_r  = $signed(w_sel_r) >>> w_sh;
    w_term_l = '0;
    w_term_r = '0;
    if (r_idx == '0) begin
      if (r_mon) begin
        w_term_l = sext(r_live_l);
        w_term_r = sext(r_live_r);
      end
    end else if (w_use) begin
      w_term_l = sext(w_shl_l);
      w_term_r = sext(w_shl_r);
    end
  end

  loop_sat u_sat_l (
    .i_acc    (r_acc_l),
    .o_sample (w_sat_l),
    .o_clip   (w_clip_l)
  );

  loop_sat u_sat_r (
    .i_acc    (r_acc_r),
    .o_sample (w_sat_r),
    .o_clip   (w_clip_r)
  );

  // Operand capture, accumulation and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_live_l <= '0;
      r_live_r <= '0;
      r_loop_l <= '0;
      r_loop_r <= '0;
      r_en     <= '0;
      r_mon    <= 1'b0;
      r_gain   <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_out_l  <= '0;
      r_out_r  <= '0;
      r_clip_l <= 1'b0;
      r_clip_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_live_l <= left_channel_audio_in;
            r_live_r <= right_channel_audio_in;
            r_loop_l <= loop_left_in;
            r_loop_r <= loop_right_in;
            r_en     <= channel_enable;
            r_mon    <= monitor_en;
            r_gain   <= gain_shift;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_idx    <= '0;
          end
        end
        ACCUM: begin
          r_acc_l <= r_acc_l + w_term_l;
          r_acc_r <= r_acc_r + w_term_r;
          r_idx   <= r_idx + IDX_W'(1);
        end
        SAT: begin
          r_out_l  <= w_sat_l;
          r_out_r  <= w_sat_r;
          r_clip_l <= w_clip_l;
          r_clip_r <= w_clip_r;
        end
        default: ;
      endcase
    end
  end

  // Sticky flag for ticks that arrive while a mix is still in flight
  always_ff @(posedge clk) begin
    if (reset)                              r_overrun <= 1'b0;
    else if (sample_tick && r_state != IDLE) r_overrun <= 1'b1;
  end

  assign write_audio_out         = (r_state == OUT) && audio_out_allowed;
  assign busy                    = (r_state != IDLE);
  assign left_channel_audio_out  = r_out_l;
  assign right_channel_audio_out = r_out_r;
  assign clip_left               = r_clip_l;
  assign clip_right              = r_clip_r;
  assign overrun                 = r_overrun;

endmodule

// File: tb/tb_loop_mixer.sv
// Self-checking bench for loop_mixer: directed scenarios plus randomized mixes
// checked against an integer-arithmetic reference model.
module tb_loop_mixer;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_tick;
  logic [31:0]  left_channel_audio_in;
  logic [31:0]  right_channel_audio_in;
  logic [127:0] loop_left_in;
  logic [127:0] loop_right_in;
  logic [3:0]   channel_enable;
  logic         monitor_en;
  logic [11:0]  gain_shift;
  logic         audio_out_allowed;
  logic         write_audio_out;
  logic [31:0]  left_channel_audio_out;
  logic [31:0]  right_channel_audio_out;
  logic         clip_left;
  logic         clip_right;
  logic         overrun;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [65:0] exp_q[$];   // {clip_l, out_l, clip_r, out_r}

  always #5 clk = ~clk;

  loop_mixer dut (
    .clk                     (clk),
    .reset                   (reset),
    .sample_tick             (sample_tick),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .loop_left_in            (loop_left_in),
    .loop_right_in           (loop_right_in),
    .channel_enable          (channel_enable),
    .monitor_en              (monitor_en),
    .gain_shift              (gain_shift),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .clip_left               (clip_left),
    .clip_right              (clip_right),
    .overrun                 (overrun),
    .busy                    (busy)
  );

  // Reference: plain signed sum of the scaled terms, then clamp to 32 bits
  function automatic logic [32:0] mix_ch(input logic [31:0] live, input logic [127:0] loops,
                                         input logic [3:0] en, input logic mon,
                                         input logic [11:0] gain);
    longint acc;
    int     s;
    acc = 0;
    if (mon) begin
      s = live;
      acc = longint'(s);
    end
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        s = loops[32*k +: 32];
        acc = acc + longint'(s >>> gain[3*k +: 3]);
      end
    end
    if (acc > 64'sd2147483647)       return {1'b1, 32'h7FFFFFFF};
    else if (acc < -64'sd2147483648) return {1'b1, 32'h80000000};
    else                             return {1'b0, acc[31:0]};
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick is high for exactly one cycle (cycle 0); returns in cycle 1
  task automatic pulse_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Bounded wait for the write strobe; cyc is the cycle number it was seen in, 0 on timeout.
  // On success returns at the falling edge of that cycle.
  task automatic wait_write(input int budget, output int cyc);
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (write_audio_out) begin
        cyc = c;
        break;
      end
      step();
    end
  endtask

  task automatic set_defaults();
    sample_tick            = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    loop_left_in           = '0;
    loop_right_in          = '0;
    channel_enable         = '0;
    monitor_en             = 1'b0;
    gain_shift             = '0;
    audio_out_allowed      = 1'b1;
  endtask

  task automatic test_reset();
    set_defaults();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if ({write_audio_out, left_channel_audio_out, right_channel_audio_out, clip_left,
         clip_right, overrun, busy} !== 69'd0)
      begin n_errors++; $display("FAIL reset_outputs: got w=%b l=%h r=%h cl=%b cr=%b ov=%b busy=%b expected all 0",
        write_audio_out, left_channel_audio_out, right_channel_audio_out, clip_left, clip_right, overrun, busy); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    left_channel_audio_in  = 32'h00001000;
    right_channel_audio_in = 32'h00001000;
    loop_left_in           = {4{32'h00001000}};
    loop_right_in          = {4{32'h00001000}};
    channel_enable         = 4'hF;
    monitor_en             = 1'b1;
    gain_shift             = '0;
    audio_out_allowed      = 1'b1;
    pulse_tick();
    wait_write(20, cyc);
    n_checks++;
    if (cyc !== 7) begin n_errors++; $display("FAIL basic_latency: got cycle %0d expected 7", cyc); end
    n_checks++;
    if (left_channel_audio_out !== 32'h00005000 || right_channel_audio_out !== 32'h00005000)
      begin n_errors++; $display("FAIL basic_sum: got l=%h r=%h expected 00005000", left_channel_audio_out, right_channel_audio_out); end
    n_checks++;
    if (clip_left !== 1'b0 || clip_right !== 1'b0)
      begin n_errors++; $display("FAIL basic_clip: got %b%b expected 00", clip_left, clip_right); end
    step();
    @(negedge clk);
    n_checks++;
    if (write_audio_out !== 1'b0 || busy !== 1'b0)
      begin n_errors++; $display("FAIL basic_single_write: got w=%b busy=%b expected 0 0", write_audio_out, busy); end
    step();
  endtask

  task automatic test_clip();
    int cyc;
    set_defaults();
    monitor_en             = 1'b1;
    channel_enable         = 4'b0001;
    left_channel_audio_in  = 32'h7FFFFFFF;
    right_channel_audio_in = 32'h80000000;
    loop_left_in           = {96'h0, 32'h00000010};
    loop_right_in          = {96'h0, 32'hFFFFFFFF};
    pulse_tick();
    wait_write(20, cyc);
    n_checks++;
    if (left_channel_audio_out !== 32'h7FFFFFFF || clip_left !== 1'b1)
      begin n_errors++; $display("FAIL clip_pos: got %h clip=%b expected 7fffffff clip=1", left_channel_audio_out, clip_left); end
    n_checks++;
    if (right_channel_audio_out !== 32'h80000000 || clip_right !== 1'b1)
      begin n_errors++; $display("FAIL clip_neg: got %h clip=%b expected 80000000 clip=1", right_channel_audio_out, clip_right); end
    step();
  endtask

  task automatic test_gain();
    int cyc;
    set_defaults();
    monitor_en             = 1'b0;
    left_channel_audio_in  = 32'h12345678;
    right_channel_audio_in = 32'h12345678;
    channel_enable         = 4'b0010;
    gain_shift             = 12'h010;
    loop_left_in           = {32'h00000100, 32'h0, 32'hFFFFF000, 32'h0};
    loop_right_in          = {32'h00000100, 32'h0, 32'hFFFFF000, 32'h0};
    pulse_tick();
    wait_write(20, cyc);
    n_checks++;
    if (left_channel_audio_out !== 32'hFFFFFC00 || right_channel_audio_out !== 32'hFFFFFC00)
      begin n_errors++; $display("FAIL gain_shift: got l=%h r=%h expected fffffc00", left_channel_audio_out, right_channel_audio_out); end
    n_checks++;
    if (clip_left !== 1'b0 || clip_right !== 1'b0)
      begin n_errors++; $display("FAIL gain_clip: got %b%b expected 00", clip_left, clip_right); end
    step();
  endtask

  task automatic test_overrun();
    int cyc;
    int writes;
    set_defaults();
    monitor_en             = 1'b1;
    left_channel_audio_in  = 32'h00000100;
    right_channel_audio_in = 32'h00000100;
    audio_out_allowed      = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_initial: got %b expected 0", overrun); end
    pulse_tick();
    writes = 0;
    for (int c = 1; c <= 20; c++) begin
      sample_tick = (c == 12);
      if (c == 12) begin
        left_channel_audio_in  = 32'h00000200;
        right_channel_audio_in = 32'h00000200;
      end
      @(negedge clk);
      if (write_audio_out) writes++;
      step();
    end
    sample_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (writes !== 0) begin n_errors++; $display("FAIL overrun_no_write: got %0d writes expected 0", writes); end
    n_checks++;
    if (overrun !== 1'b1 || busy !== 1'b1)
      begin n_errors++; $display("FAIL overrun_flag: got ov=%b busy=%b expected 1 1", overrun, busy); end
    n_checks++;
    if (left_channel_audio_out !== 32'h00000100 || right_channel_audio_out !== 32'h00000100)
      begin n_errors++; $display("FAIL overrun_held: got l=%h r=%h expected 00000100", left_channel_audio_out, right_channel_audio_out); end
    step();
    audio_out_allowed = 1'b1;
    wait_write(5, cyc);
    n_checks++;
    if (cyc !== 1 || left_channel_audio_out !== 32'h00000100)
      begin n_errors++; $display("FAIL overrun_release: got cycle %0d l=%h expected cycle 1 l=00000100", cyc, left_channel_audio_out); end
    step();
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_audio_out) writes++;
      step();
    end
    n_checks++;
    if (writes !== 0 || busy !== 1'b0 || overrun !== 1'b1)
      begin n_errors++; $display("FAIL overrun_after: got writes=%0d busy=%b ov=%b expected 0 0 1", writes, busy, overrun); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int writes;
    set_defaults();
    monitor_en             = 1'b1;
    left_channel_audio_in  = 32'h00000777;
    right_channel_audio_in = 32'h00000777;
    pulse_tick();          // now in cycle 1
    step();                // cycle 2
    step();                // cycle 3
    reset = 1'b1;
    step();                // cycle 4
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({write_audio_out, left_channel_audio_out, right_channel_audio_out, clip_left,
         clip_right, overrun, busy} !== 69'd0)
      begin n_errors++; $display("FAIL reset_mid: got w=%b l=%h r=%h cl=%b cr=%b ov=%b busy=%b expected all 0",
        write_audio_out, left_channel_audio_out, right_channel_audio_out, clip_left, clip_right, overrun, busy); end
    step();
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_audio_out) writes++;
      step();
    end
    n_checks++;
    if (writes !== 0) begin n_errors++; $display("FAIL reset_mid_discard: got %0d writes expected 0", writes); end
    left_channel_audio_in  = 32'h00000010;
    right_channel_audio_in = 32'h00000010;
    channel_enable         = 4'b0100;
    gain_shift             = 12'h040;
    loop_left_in           = {32'h0, 32'h00000020, 64'h0};
    loop_right_in          = {32'h0, 32'h00000020, 64'h0};
    pulse_tick();
    wait_write(20, cyc);
    n_checks++;
    if (cyc !== 7 || left_channel_audio_out !== 32'h00000020 || right_channel_audio_out !== 32'h00000020)
      begin n_errors++; $display("FAIL reset_mid_recover: got cycle %0d l=%h r=%h expected 7 00000020", cyc, left_channel_audio_out, right_channel_audio_out); end
    step();
  endtask

  task automatic test_capture();
    int cyc;
    set_defaults();
    channel_enable = 4'hF;
    loop_left_in   = {4{32'h00001000}};
    loop_right_in  = {4{32'h00002000}};
    pulse_tick();          // cycle 1
    step();                // cycle 2
    loop_left_in   = {4{32'h07000000}};
    gain_shift     = 12'hFFF;
    channel_enable = 4'h0;
    monitor_en     = 1'b1;
    wait_write(20, cyc);
    n_checks++;
    if (left_channel_audio_out !== 32'h00004000 || right_channel_audio_out !== 32'h00008000)
      begin n_errors++; $display("FAIL capture: got l=%h r=%h expected 00004000 00008000", left_channel_audio_out, right_channel_audio_out); end
    step();
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 1) == 0) v = {{12{v[31]}}, v[19:0]};
    return v;
  endfunction

  task automatic test_random();
    int cyc;
    logic [65:0] exp;
    for (int n = 0; n < 40; n++) begin
      left_channel_audio_in  = rand_sample();
      right_channel_audio_in = rand_sample();
      loop_left_in           = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
      loop_right_in          = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
      channel_enable         = 4'($urandom);
      monitor_en             = 1'($urandom);
      gain_shift             = 12'($urandom);
      audio_out_allowed      = 1'b1;
      exp_q.push_back({mix_ch(left_channel_audio_in, loop_left_in, channel_enable, monitor_en, gain_shift),
                       mix_ch(right_channel_audio_in, loop_right_in, channel_enable, monitor_en, gain_shift)});
      pulse_tick();
      loop_left_in  = {$urandom, $urandom, $urandom, $urandom};
      loop_right_in = {$urandom, $urandom, $urandom, $urandom};
      wait_write(20, cyc);
      exp = exp_q.pop_front();
      n_checks++;
      if (cyc !== 7 || {clip_left, left_channel_audio_out, clip_right, right_channel_audio_out} !== exp)
        begin n_errors++; $display("FAIL random_mix[%0d]: got cycle %0d {cl,l,cr,r}=%h expected cycle 7 %h",
          n, cyc, {clip_left, left_channel_audio_out, clip_right, right_channel_audio_out}, exp); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_gain();
    test_overrun();
    test_reset_mid();
    test_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loop_mixer.md
Name: loop_mixer

Overview:
- Downstream of the loop record/playback engine: takes the live codec input plus the four per-loop playback samples (left and right) and sums them into one output sample pair.
- Applies a per-loop enable and attenuation, then saturates the sum.
- Hands the result to the audio codec output port with the codec's write/allowed handshake.
- Replaces the unsaturated combinational adder currently on the codec output path. Runs entirely on the 50 MHz system clock; one mix per sample_tick.

Parameters:
- NUM_LOOPS, 4, number of loop channels mixed.
- SAMPLE_W, 32, width of every audio sample (signed two's complement).
- ACC_W, 35, accumulator width; must be at least SAMPLE_W + clog2(NUM_LOOPS+1).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse per 48 kHz frame, already synchronised to clk
- left_channel_audio_in  in  32  live left sample
- right_channel_audio_in  in  32  live right sample
- loop_left_in  in  128  loop left samples packed; loop k at bits [32k+31:32k]
- loop_right_in  in  128  loop right samples, same packing
- channel_enable  in  4  per-loop mix enable
- monitor_en  in  1  include the live input in the mix
- gain_shift  in  12  per-loop arithmetic right shift 0..7; loop k at bits [3k+2:3k]
- audio_out_allowed  in  1  codec output FIFO can accept a sample
- write_audio_out  out  1  transfer strobe to the codec
- left_channel_audio_out  out  32  mixed left sample
- right_channel_audio_out  out  32  mixed right sample
- clip_left  out  1  last output left sample was saturated
- clip_right  out  1  last output right sample was saturated
- overrun  out  1  sticky: a sample_tick arrived while not IDLE
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; accumulators and captured operands 0. Reset in any state aborts the mix and discards the pending sample with no write_audio_out. Reset takes priority over a same-cycle sample_tick.
- States and transitions:
  - IDLE -> ACCUM on sample_tick. All inputs, including enables, gains and monitor_en, are captured on that edge.
  - ACCUM lasts 5 cycles with idx 0..4, left and right in parallel. idx0 adds the live term: sign-extended input if monitor_en, else 0. idx k (1..4) adds loop k-1: (sample >>> gain_shift[k-1]) sign-extended if channel_enable[k-1], else 0. The accumulator clears on IDLE->ACCUM entry.
  - SAT lasts 1 cycle. If acc > 0x7FFFFFFF the output is 0x7FFFFFFF; if acc < -0x80000000 it is 0x80000000; otherwise acc[31:0]. The result loads the output registers, and the clip flags load on the same edge. Outputs and clip flags hold until the next SAT.
  - OUT: write_audio_out = (state==OUT) & audio_out_allowed, combinational. On the edge where it is high, the state returns to IDLE. While audio_out_allowed is low, the state stays OUT indefinitely with outputs held.
- Latency: sample_tick high in cycle 0; ACCUM in cycles 1–5; SAT in cycle 6; earliest write_audio_out in cycle 7. At most one write per tick. write_audio_out is high for exactly one cycle per accepted sample.
- sample_tick while busy (ACCUM, SAT or OUT): the tick is ignored, the current mix is unaffected, and overrun is set. overrun is cleared only by reset.
- A sample_tick in the same cycle as the OUT->IDLE transfer is ignored and sets overrun. A tick is only accepted in IDLE.
- Changes to inputs after the capture edge have no effect on the mix in progress.

Decomposition:
- Package loop_pkg: NUM_LOOPS, SAMPLE_W, ACC_W, the state enum (IDLE, ACCUM, SAT, OUT), and MAX_POS/MAX_NEG constants.
- One sub-module, loop_sat: combinational ACC_W -> SAMPLE_W saturator with a clip flag. Instantiated twice (left, right).

Test Plan:
1. Live 0x00001000, all loops 0x00001000, channel_enable 4'hF, monitor_en 1, gain 0, audio_out_allowed 1 -> write_audio_out high in cycle 7 only; both outputs 0x00005000; clip flags 0.
2. Live 0x7FFFFFFF, loop0 0x00000010, other loops disabled -> left 0x7FFFFFFF, clip_left 1. Live 0x80000000, loop0 0xFFFFFFFF -> 0x80000000, clip 1.
3. monitor_en 0, loop1 0xFFFFF000 with gain_shift[5:3]=2, only channel 1 enabled -> output 0xFFFFFC00 (-1024); loop3 0x00000100 with channel_enable[3]=0 contributes 0.
4. Hold audio_out_allowed low 20 cycles after a tick; pulse sample_tick again in cycle 12 -> overrun 1, outputs unchanged. Raise allowed -> exactly one write_audio_out with the first mix, then IDLE.
5. Assert reset in ACCUM cycle 3 -> next cycle: all outputs 0, busy 0, no write_audio_out. A subsequent tick mixes normally.
6. Change loop_left_in in cycle 2 after a tick -> output reflects the cycle-0 captured values.
